armleocpu_csr_trap: RTL and testbench

ARMLEOCPU_CSR_TRAP -- requirements
Module: armleocpu_csr_trap

---
 rtl/armleocpu_csr_pkg.sv | 57 +++++
 rtl/armleocpu_csr_counter.sv | 26 ++
 rtl/armleocpu_csr_trap.sv | 219 +++++++++++++++++++++
 tb/tb_armleocpu_csr_trap.sv | 277 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/armleocpu_csr_pkg.sv
// Shared CSR command encodings, privilege levels and CSR address map.
package armleocpu_csr_pkg;

    typedef enum logic [3:0] {
        CSR_CMD_NONE            = 4'd0,
        CSR_CMD_WRITE           = 4'd1,
        CSR_CMD_READ            = 4'd2,
        CSR_CMD_READ_WRITE      = 4'd3,
        CSR_CMD_READ_SET        = 4'd4,
        CSR_CMD_READ_CLEAR      = 4'd5,
        CSR_CMD_MRET            = 4'd6,
        CSR_CMD_SRET            = 4'd7,
        CSR_CMD_INTERRUPT_BEGIN = 4'd8,
        CSR_CMD_EXCEPTION_BEGIN = 4'd9
    } csr_cmd_t;

    localparam logic [1:0] PRIV_U = 2'b00;
    localparam logic [1:0] PRIV_S = 2'b01;
    localparam logic [1:0] PRIV_M = 2'b11;

    localparam logic [11:0] CSR_MVENDORID  = 12'hF11;
    localparam logic [11:0] CSR_MHARTID    = 12'hF14;
    localparam logic [11:0] CSR_MCURRPRIV  = 12'hFC0;
    localparam logic [11:0] CSR_MSTATUS    = 12'h300;
    localparam logic [11:0] CSR_MISA       = 12'h301;
    localparam logic [11:0] CSR_MTVEC      = 12'h305;
    localparam logic [11:0] CSR_MSCRATCH   = 12'h340;
    localparam logic [11:0] CSR_MEPC       = 12'h341;
    localparam logic [11:0] CSR_MCAUSE     = 12'h342;
    localparam logic [11:0] CSR_STVEC      = 12'h105;
    localparam logic [11:0] CSR_SSCRATCH   = 12'h140;
    localparam logic [11:0] CSR_SEPC       = 12'h141;
    localparam logic [11:0] CSR_SCAUSE     = 12'h142;
    localparam logic [11:0] CSR_MCYCLE     = 12'hB00;
    localparam logic [11:0] CSR_MCYCLEH    = 12'hB80;
    localparam logic [11:0] CSR_MINSTRET   = 12'hB02;
    localparam logic [11:0] CSR_MINSTRETH  = 12'hB82;
    localparam logic [11:0] CSR_CYCLE      = 12'hC00;
    localparam logic [11:0] CSR_CYCLEH     = 12'hC80;
    localparam logic [11:0] CSR_INSTRET    = 12'hC02;
    localparam logic [11:0] CSR_INSTRETH   = 12'hC82;

    // MXL=32, extensions I, M, S, U; the A bit is held separately
    localparam logic [31:0] MISA_FIXED = 32'h4014_1100;

    // New CSR value for the read-modify-write command family
    function automatic logic [31:0] csr_apply(input csr_cmd_t cmd,
                                              input logic [31:0] old_value,
                                              input logic [31:0] wd);
        case (cmd)
            CSR_CMD_READ_SET:   csr_apply = old_value | wd;
            CSR_CMD_READ_CLEAR: csr_apply = old_value & ~wd;
            default:            csr_apply = wd;
        endcase
    endfunction

endpackage

// File: rtl/armleocpu_csr_counter.sv
// Free-running counter with independent 32-bit low/high write ports.
module armleocpu_csr_counter #(
    parameter int unsigned WIDTH = 64
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             incr,
    input  logic             write_lo,
    input  logic             write_hi,
    input  logic [31:0]      writedata,
    output logic [WIDTH-1:0] value
);

    // A write to either half wins over that cycle's increment
    always_ff @(posedge clk) begin
        if (!rst_n)
            value <= '0;
        else if (write_lo)
            value[31:0] <= writedata;
        else if (write_hi)
            value[WIDTH-1:32] <= writedata[WIDTH-33:0];
        else if (incr)
            value <= value + WIDTH'(1);
    end

endmodule

// File: rtl/armleocpu_csr_trap.sv
// Machine/supervisor CSR file with trap entry and return handling.
module armleocpu_csr_trap
    import armleocpu_csr_pkg::*;
#(
    parameter logic [31:0] MHARTID       = 32'h0,
    parameter logic [31:0] MVENDORID     = 32'h0A1AA1E0,
    parameter int unsigned COUNTER_WIDTH = 64
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [3:0]  csr_cmd,
    input  logic [11:0] csr_address,
    input  logic [31:0] csr_writedata,
    output logic [31:0] csr_readdata,
    output logic        csr_invalid,
    input  logic [30:0] csr_exc_cause,
    input  logic [31:0] csr_exc_epc,
    input  logic        csr_instret_incr,
    output logic [31:0] csr_next_pc,
    output logic [1:0]  csr_mcurrent_privilege,
    output logic [31:0] csr_mtvec,
    output logic [31:0] csr_stvec,
    output logic [31:0] csr_mepc,
    output logic [31:0] csr_sepc,
    output logic        csr_mstatus_mprv,
    output logic        csr_mstatus_mxr,
    output logic        csr_mstatus_sum,
    output logic        csr_mstatus_tsr,
    output logic        csr_mstatus_tw,
    output logic        csr_mstatus_tvm,
    output logic        csr_mstatus_mie,
    output logic        csr_mstatus_sie,
    output logic [1:0]  csr_mstatus_mpp
);

    csr_cmd_t cmd;
    assign cmd = csr_cmd_t'(csr_cmd);

    logic        mstatus_mpie, mstatus_spie, mstatus_spp, misa_a;
    logic [31:0] mscratch, mcause, sscratch, scause;
    logic [31:0] mstatus_value;

    logic [COUNTER_WIDTH-1:0] mcycle, minstret;
    logic [63:0] mcycle_ext, minstret_ext;
    assign mcycle_ext   = 64'(mcycle);
    assign minstret_ext = 64'(minstret);

    logic        implemented, is_csr_cmd, write_class, csr_ok, do_write;
    logic [31:0] old_value, new_value;

    // Pack the individual status bits into the architectural mstatus word
    always_comb begin
        mstatus_value        = '0;
        mstatus_value[1]     = csr_mstatus_sie;
        mstatus_value[3]     = csr_mstatus_mie;
        mstatus_value[5]     = mstatus_spie;
        mstatus_value[7]     = mstatus_mpie;
        mstatus_value[8]     = mstatus_spp;
        mstatus_value[12:11] = csr_mstatus_mpp;
        mstatus_value[17]    = csr_mstatus_mprv;
        mstatus_value[18]    = csr_mstatus_sum;
        mstatus_value[19]    = csr_mstatus_mxr;
        mstatus_value[20]    = csr_mstatus_tvm;
        mstatus_value[21]    = csr_mstatus_tw;
        mstatus_value[22]    = csr_mstatus_tsr;
    end

    // Address decode: current value of the addressed CSR and whether it exists
    always_comb begin
        old_value   = '0;
        implemented = 1'b1;
        case (csr_address)
            CSR_MVENDORID:              old_value = MVENDORID;
            CSR_MHARTID:                old_value = MHARTID;
            CSR_MCURRPRIV:              old_value = {30'd0, csr_mcurrent_privilege};
            CSR_MSTATUS:                old_value = mstatus_value;
            CSR_MISA:                   old_value = MISA_FIXED | {31'd0, misa_a};
            CSR_MTVEC:                  old_value = csr_mtvec;
            CSR_MSCRATCH:               old_value = mscratch;
            CSR_MEPC:                   old_value = csr_mepc;
            CSR_MCAUSE:                 old_value = mcause;
            CSR_STVEC:                  old_value = csr_stvec;
            CSR_SSCRATCH:               old_value = sscratch;
            CSR_SEPC:                   old_value = csr_sepc;
            CSR_SCAUSE:                 old_value = scause;
            CSR_MCYCLE, CSR_CYCLE:      old_value = mcycle_ext[31:0];
            CSR_MCYCLEH, CSR_CYCLEH:    old_value = mcycle_ext[63:32];
            CSR_MINSTRET, CSR_INSTRET:  old_value = minstret_ext[31:0];
            CSR_MINSTRETH, CSR_INSTRETH: old_value = minstret_ext[63:32];
            default:                    implemented = 1'b0;
        endcase
    end

    // Legality check and combinational outputs for the current command
    always_comb begin
        is_csr_cmd  = cmd inside {CSR_CMD_WRITE, CSR_CMD_READ, CSR_CMD_READ_WRITE,
                                  CSR_CMD_READ_SET, CSR_CMD_READ_CLEAR};
        write_class = (cmd == CSR_CMD_WRITE) || (cmd == CSR_CMD_READ_WRITE) ||
                      (((cmd == CSR_CMD_READ_SET) || (cmd == CSR_CMD_READ_CLEAR)) &&
                       (csr_writedata != '0));
        csr_invalid = 1'b0;
        if (is_csr_cmd)
            csr_invalid = (csr_mcurrent_privilege < csr_address[9:8]) || !implemented ||
                          (write_class && (csr_address[11:10] == 2'b11));
        else if (cmd == CSR_CMD_MRET)
            csr_invalid = (csr_mcurrent_privilege != PRIV_M);
        else if (cmd == CSR_CMD_SRET)
            csr_invalid = (csr_mcurrent_privilege == PRIV_U) ||
                          ((csr_mcurrent_privilege == PRIV_S) && csr_mstatus_tsr);

        csr_ok    = is_csr_cmd && !csr_invalid;
        do_write  = csr_ok && write_class;
        new_value = csr_apply(cmd, old_value, csr_writedata);

        csr_readdata = (csr_ok && (cmd != CSR_CMD_WRITE)) ? old_value : '0;

        csr_next_pc = '0;
        if ((cmd == CSR_CMD_EXCEPTION_BEGIN) || (cmd == CSR_CMD_INTERRUPT_BEGIN))
            csr_next_pc = csr_mtvec;
        else if ((cmd == CSR_CMD_MRET) && !csr_invalid)
            csr_next_pc = csr_mepc;
        else if ((cmd == CSR_CMD_SRET) && !csr_invalid)
            csr_next_pc = csr_sepc;
    end

    armleocpu_csr_counter #(.WIDTH(COUNTER_WIDTH)) u_mcycle (
        .clk       (clk),
        .rst_n     (rst_n),
        .incr      (1'b1),
        .write_lo  (do_write && (csr_address == CSR_MCYCLE)),
        .write_hi  (do_write && (csr_address == CSR_MCYCLEH)),
        .writedata (new_value),
        .value     (mcycle)
    );

    armleocpu_csr_counter #(.WIDTH(COUNTER_WIDTH)) u_minstret (
        .clk       (clk),
        .rst_n     (rst_n),
        .incr      (csr_instret_incr),
        .write_lo  (do_write && (csr_address == CSR_MINSTRET)),
        .write_hi  (do_write && (csr_address == CSR_MINSTRETH)),
        .writedata (new_value),
        .value     (minstret)
    );

    // Trap entry, trap return and CSR writes; only one can apply per cycle
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            csr_mcurrent_privilege <= PRIV_M;
            csr_mstatus_mprv <= 1'b0;
            csr_mstatus_mxr  <= 1'b0;
            csr_mstatus_sum  <= 1'b0;
            csr_mstatus_tsr  <= 1'b0;
            csr_mstatus_tw   <= 1'b0;
            csr_mstatus_tvm  <= 1'b0;
            csr_mstatus_mie  <= 1'b0;
            csr_mstatus_sie  <= 1'b0;
            csr_mstatus_mpp  <= 2'b00;
            mstatus_mpie     <= 1'b0;
            mstatus_spie     <= 1'b0;
            mstatus_spp      <= 1'b0;
            misa_a           <= 1'b0;
            csr_mtvec        <= '0;
            csr_stvec        <= '0;
            csr_mepc         <= '0;
            csr_sepc         <= '0;
            mscratch         <= '0;
            mcause           <= '0;
            sscratch         <= '0;
            scause           <= '0;
        end else if ((cmd == CSR_CMD_EXCEPTION_BEGIN) || (cmd == CSR_CMD_INTERRUPT_BEGIN)) begin
            csr_mepc               <= csr_exc_epc;
            mcause                 <= {cmd == CSR_CMD_INTERRUPT_BEGIN, csr_exc_cause};
            mstatus_mpie           <= csr_mstatus_mie;
            csr_mstatus_mie        <= 1'b0;
            csr_mstatus_mpp        <= csr_mcurrent_privilege;
            csr_mcurrent_privilege <= PRIV_M;
        end else if ((cmd == CSR_CMD_MRET) && !csr_invalid) begin
            csr_mcurrent_privilege <= csr_mstatus_mpp;
            csr_mstatus_mie        <= mstatus_mpie;
            mstatus_mpie           <= 1'b1;
            csr_mstatus_mpp        <= PRIV_U;
        end else if ((cmd == CSR_CMD_SRET) && !csr_invalid) begin
            csr_mcurrent_privilege <= {1'b0, mstatus_spp};
            csr_mstatus_sie        <= mstatus_spie;
            mstatus_spie           <= 1'b1;
            mstatus_spp            <= 1'b0;
        end else if (do_write) begin
            case (csr_address)
                CSR_MSTATUS: begin
                    csr_mstatus_sie  <= new_value[1];
                    csr_mstatus_mie  <= new_value[3];
                    mstatus_spie     <= new_value[5];
                    mstatus_mpie     <= new_value[7];
                    mstatus_spp      <= new_value[8];
                    if (new_value[12:11] != 2'b10)
                        csr_mstatus_mpp <= new_value[12:11];
                    csr_mstatus_mprv <= new_value[17];
                    csr_mstatus_sum  <= new_value[18];
                    csr_mstatus_mxr  <= new_value[19];
                    csr_mstatus_tvm  <= new_value[20];
                    csr_mstatus_tw   <= new_value[21];
                    csr_mstatus_tsr  <= new_value[22];
                end
                CSR_MISA:     misa_a <= new_value[0];
                CSR_MTVEC:    if (csr_writedata[1:0] == 2'b00) csr_mtvec <= new_value;
                CSR_MEPC:     if (csr_writedata[1:0] == 2'b00) csr_mepc  <= new_value;
                CSR_STVEC:    if (csr_writedata[1:0] == 2'b00) csr_stvec <= new_value;
                CSR_SEPC:     if (csr_writedata[1:0] == 2'b00) csr_sepc  <= new_value;
                CSR_MSCRATCH: mscratch <= new_value;
                CSR_MCAUSE:   mcause   <= new_value;
                CSR_SSCRATCH: sscratch <= new_value;
                CSR_SCAUSE:   scause   <= new_value;
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_armleocpu_csr_trap.sv
// Randomized self-checking bench for armleocpu_csr_trap against an architectural model.
module tb_armleocpu_csr_trap;

    localparam int unsigned CW     = 40;
    localparam logic [31:0] HARTID = 32'h0000_0005;
    localparam logic [31:0] VENDOR = 32'h0A1A_A1E0;
    localparam logic [63:0] CMASK  = (64'd1 << CW) - 64'd1;
    localparam logic [31:0] MS_WMASK  = 32'h007E_19AA;
    localparam logic [31:0] MISA_BASE = 32'h4014_1100;

    localparam logic [3:0] C_NONE = 4'd0, C_WRITE = 4'd1, C_READ = 4'd2, C_RW = 4'd3,
                           C_SET = 4'd4, C_CLR = 4'd5, C_MRET = 4'd6, C_SRET = 4'd7,
                           C_INT = 4'd8, C_EXC = 4'd9;

    logic        clk, rst_n;
    logic [3:0]  csr_cmd;
    logic [11:0] csr_address;
    logic [31:0] csr_writedata, csr_readdata, csr_exc_epc, csr_next_pc;
    logic        csr_invalid, csr_instret_incr;
    logic [30:0] csr_exc_cause;
    logic [1:0]  csr_mcurrent_privilege, csr_mstatus_mpp;
    logic [31:0] csr_mtvec, csr_stvec, csr_mepc, csr_sepc;
    logic        csr_mstatus_mprv, csr_mstatus_mxr, csr_mstatus_sum, csr_mstatus_tsr;
    logic        csr_mstatus_tw, csr_mstatus_tvm, csr_mstatus_mie, csr_mstatus_sie;

    int checks = 0;
    int errors = 0;

    // architectural model state
    logic [1:0]  m_priv;
    logic [31:0] m_mstatus;
    logic        m_misa_a;
    logic [31:0] m_plain [int];
    logic [63:0] m_cycle, m_instret;

    logic [11:0] addr_tab [24] = '{12'hF11, 12'hF14, 12'hFC0, 12'h300, 12'h301, 12'h305,
                                   12'h340, 12'h341, 12'h342, 12'h105, 12'h140, 12'h141,
                                   12'h142, 12'hB00, 12'hB80, 12'hB02, 12'hB82, 12'hC00,
                                   12'hC80, 12'hC02, 12'hC82, 12'h7C0, 12'h3A0, 12'hF12};

    armleocpu_csr_trap #(.MHARTID(HARTID), .MVENDORID(VENDOR), .COUNTER_WIDTH(CW)) dut (
        .clk(clk), .rst_n(rst_n), .csr_cmd(csr_cmd), .csr_address(csr_address),
        .csr_writedata(csr_writedata), .csr_readdata(csr_readdata), .csr_invalid(csr_invalid),
        .csr_exc_cause(csr_exc_cause), .csr_exc_epc(csr_exc_epc),
        .csr_instret_incr(csr_instret_incr), .csr_next_pc(csr_next_pc),
        .csr_mcurrent_privilege(csr_mcurrent_privilege), .csr_mtvec(csr_mtvec),
        .csr_stvec(csr_stvec), .csr_mepc(csr_mepc), .csr_sepc(csr_sepc),
        .csr_mstatus_mprv(csr_mstatus_mprv), .csr_mstatus_mxr(csr_mstatus_mxr),
        .csr_mstatus_sum(csr_mstatus_sum), .csr_mstatus_tsr(csr_mstatus_tsr),
        .csr_mstatus_tw(csr_mstatus_tw), .csr_mstatus_tvm(csr_mstatus_tvm),
        .csr_mstatus_mie(csr_mstatus_mie), .csr_mstatus_sie(csr_mstatus_sie),
        .csr_mstatus_mpp(csr_mstatus_mpp)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic bit model_lookup(input logic [11:0] a, output logic [31:0] v);
        v = '0;
        if (m_plain.exists(int'(a))) begin
            v = m_plain[int'(a)];
            return 1'b1;
        end
        case (a)
            12'hF11: v = VENDOR;
            12'hF14: v = HARTID;
            12'hFC0: v = {30'd0, m_priv};
            12'h300: v = m_mstatus;
            12'h301: v = MISA_BASE | {31'd0, m_misa_a};
            12'hB00, 12'hC00: v = m_cycle[31:0];
            12'hB80, 12'hC80: v = m_cycle[63:32];
            12'hB02, 12'hC02: v = m_instret[31:0];
            12'hB82, 12'hC82: v = m_instret[63:32];
            default: return 1'b0;
        endcase
        return 1'b1;
    endfunction

    task automatic model_reset();
        m_priv = 2'b11; m_mstatus = '0; m_misa_a = 1'b0;
        m_cycle = '0; m_instret = '0;
        foreach (addr_tab[i])
            if (addr_tab[i][11:8] == 4'h3 || addr_tab[i][11:8] == 4'h1)
                if (addr_tab[i] != 12'h300 && addr_tab[i] != 12'h301 && addr_tab[i] != 12'h3A0)
                    m_plain[int'(addr_tab[i])] = '0;
    endtask

    task automatic check_state();
        logic [31:0] ms;
        ms = '0;
        ms[1] = csr_mstatus_sie;  ms[3] = csr_mstatus_mie;  ms[12:11] = csr_mstatus_mpp;
        ms[17] = csr_mstatus_mprv; ms[18] = csr_mstatus_sum; ms[19] = csr_mstatus_mxr;
        ms[20] = csr_mstatus_tvm; ms[21] = csr_mstatus_tw;  ms[22] = csr_mstatus_tsr;
        check_eq("privilege", csr_mcurrent_privilege, m_priv);
        check_eq("mstatus_out", ms, m_mstatus & 32'h007E_180A);
        check_eq("mtvec", csr_mtvec, m_plain[32'h305]);
        check_eq("mepc", csr_mepc, m_plain[32'h341]);
        check_eq("stvec", csr_stvec, m_plain[32'h105]);
        check_eq("sepc", csr_sepc, m_plain[32'h141]);
    endtask

    // One command cycle: check combinational outputs, clock, advance model, check state
    task automatic do_cycle(input logic [3:0] cmd, input logic [11:0] a, input logic [31:0] wd,
                            input logic [30:0] cause, input logic [31:0] epc, input logic incr);
        bit impl, csrc, wcls, inval, cyc_w, ins_w;
        logic [31:0] old, nv, exp_rd, exp_npc;
        logic [1:0] mpp;
        csr_cmd = cmd; csr_address = a; csr_writedata = wd;
        csr_exc_cause = cause; csr_exc_epc = epc; csr_instret_incr = incr;
        #2;
        impl = model_lookup(a, old);
        csrc = (cmd >= C_WRITE) && (cmd <= C_CLR);
        wcls = (cmd == C_WRITE) || (cmd == C_RW) || ((cmd == C_SET || cmd == C_CLR) && wd != 0);
        inval = 1'b0;
        if (csrc) inval = (m_priv < a[9:8]) || !impl || (wcls && a[11:10] == 2'b11);
        else if (cmd == C_MRET) inval = (m_priv != 2'b11);
        else if (cmd == C_SRET) inval = (m_priv == 2'b00) || (m_priv == 2'b01 && m_mstatus[22]);
        exp_rd = (csrc && !inval && cmd != C_WRITE) ? old : 32'd0;
        exp_npc = 32'd0;
        if (cmd == C_EXC || cmd == C_INT) exp_npc = m_plain[32'h305];
        else if (cmd == C_MRET && !inval) exp_npc = m_plain[32'h341];
        else if (cmd == C_SRET && !inval) exp_npc = m_plain[32'h141];
        nv = (cmd == C_SET) ? (old | wd) : (cmd == C_CLR) ? (old & ~wd) : wd;
        check_eq("invalid", csr_invalid, inval);
        check_eq("readdata", csr_readdata, exp_rd);
        check_eq("next_pc", csr_next_pc, exp_npc);
        @(posedge clk);
        cyc_w = 1'b0; ins_w = 1'b0;
        if (csrc && !inval && wcls) begin
            case (a)
                12'h300: begin
                    mpp = m_mstatus[12:11];
                    m_mstatus = nv & MS_WMASK;
                    if (nv[12:11] == 2'b10) m_mstatus[12:11] = mpp;
                end
                12'h301: m_misa_a = nv[0];
                12'h305, 12'h341, 12'h105, 12'h141: if (wd[1:0] == 2'b00) m_plain[int'(a)] = nv;
                12'h340, 12'h342, 12'h140, 12'h142: m_plain[int'(a)] = nv;
                12'hB00: begin m_cycle   = {m_cycle[63:32], nv} & CMASK;   cyc_w = 1'b1; end
                12'hB80: begin m_cycle   = {nv, m_cycle[31:0]} & CMASK;    cyc_w = 1'b1; end
                12'hB02: begin m_instret = {m_instret[63:32], nv} & CMASK; ins_w = 1'b1; end
                12'hB82: begin m_instret = {nv, m_instret[31:0]} & CMASK;  ins_w = 1'b1; end
                default: ;
            endcase
        end else if (cmd == C_EXC || cmd == C_INT) begin
            m_plain[32'h341] = epc;
            m_plain[32'h342] = {cmd == C_INT, cause};
            m_mstatus[7] = m_mstatus[3];
            m_mstatus[3] = 1'b0;
            m_mstatus[12:11] = m_priv;
            m_priv = 2'b11;
        end else if (cmd == C_MRET && !inval) begin
            m_priv = m_mstatus[12:11];
            m_mstatus[3] = m_mstatus[7];
            m_mstatus[7] = 1'b1;
            m_mstatus[12:11] = 2'b00;
        end else if (cmd == C_SRET && !inval) begin
            m_priv = {1'b0, m_mstatus[8]};
            m_mstatus[1] = m_mstatus[5];
            m_mstatus[5] = 1'b1;
            m_mstatus[8] = 1'b0;
        end
        if (!cyc_w) m_cycle = (m_cycle + 64'd1) & CMASK;
        if (!ins_w && incr) m_instret = (m_instret + 64'd1) & CMASK;
        #1;
        check_state();
    endtask

    task automatic op(input logic [3:0] cmd, input logic [11:0] a, input logic [31:0] wd);
        do_cycle(cmd, a, wd, 31'd0, 32'd0, 1'b0);
    endtask

    initial begin
        logic [3:0] cmd;
        logic [31:0] wd;
        int unsigned r;
        rst_n = 1'b0;
        csr_cmd = C_EXC; csr_address = 12'h300; csr_writedata = 32'hFFFF_FFFF;
        csr_exc_cause = 31'd7; csr_exc_epc = 32'h1234; csr_instret_incr = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        model_reset();
        check_state();
        rst_n = 1'b1;

        // reset values and identity registers
        op(C_READ, 12'hFC0, 32'd0);
        check_eq("fc0_priv_m", csr_readdata, 32'd3);
        op(C_READ, 12'hB00, 32'd0);
        op(C_READ, 12'hF14, 32'd0);
        check_eq("hartid", csr_readdata, HARTID);

        // exception from U
        op(C_WRITE, 12'h305, 32'h80);
        op(C_WRITE, 12'h300, 32'd0);
        op(C_MRET, 12'h000, 32'd0);
        check_eq("to_user", csr_mcurrent_privilege, 2'd0);
        do_cycle(C_EXC, 12'h000, 32'd0, 31'd2, 32'h100, 1'b1);
        check_eq("exc_mepc", csr_mepc, 32'h100);
        check_eq("exc_mpp", csr_mstatus_mpp, 2'd0);
        check_eq("exc_priv", csr_mcurrent_privilege, 2'd3);
        op(C_READ, 12'h342, 32'd0);
        check_eq("exc_mcause", csr_readdata, 32'd2);

        // MRET to S, then MRET from S is illegal
        op(C_WRITE, 12'h300, 32'h0000_0880);
        op(C_MRET, 12'h000, 32'd0);
        check_eq("mret_priv", csr_mcurrent_privilege, 2'd1);
        check_eq("mret_mie", csr_mstatus_mie, 1'b1);
        op(C_MRET, 12'h000, 32'd0);
        check_eq("mret_from_s", csr_invalid, 1'b1);

        // SRET with TSR set, then clear
        do_cycle(C_EXC, 12'h000, 32'd0, 31'd3, 32'h44, 1'b0);
        op(C_WRITE, 12'h141, 32'h200);
        op(C_WRITE, 12'h300, 32'h0040_0900);
        op(C_MRET, 12'h000, 32'd0);
        op(C_SRET, 12'h000, 32'd0);
        check_eq("sret_tsr_priv", csr_mcurrent_privilege, 2'd1);
        do_cycle(C_INT, 12'h000, 32'd0, 31'd5, 32'h48, 1'b1);
        op(C_WRITE, 12'h300, 32'h0000_0800);
        op(C_MRET, 12'h000, 32'd0);
        op(C_SRET, 12'h000, 32'd0);
        check_eq("sret_priv", csr_mcurrent_privilege, 2'd0);
        do_cycle(C_EXC, 12'h000, 32'd0, 31'd8, 32'h4C, 1'b0);

        // counter carry, wrap at 2^CW, read-only shadows
        op(C_WRITE, 12'hB00, 32'hFFFF_FFFF);
        op(C_WRITE, 12'hB80, 32'd0);
        op(C_NONE, 12'h000, 32'd0);
        op(C_READ, 12'hC80, 32'd0);
        op(C_WRITE, 12'hC00, 32'd1);
        op(C_WRITE, 12'hB80, 32'hFFFF_FFFF);
        op(C_WRITE, 12'hB00, 32'hFFFF_FFFE);
        op(C_READ, 12'hB80, 32'd0);
        op(C_READ, 12'hB80, 32'd0);
        check_eq("cycle_wrap", csr_readdata, 32'd0);
        op(C_WRITE, 12'hB02, 32'hFFFF_FFFF);
        do_cycle(C_READ, 12'hB82, 32'd0, 31'd0, 32'd0, 1'b1);
        do_cycle(C_READ, 12'hC82, 32'd0, 31'd0, 32'd0, 1'b1);

        // set/clear on scratch, zero-mask set on read-only CSR
        op(C_WRITE, 12'h340, 32'hF0);
        op(C_SET, 12'h340, 32'h0F);
        op(C_CLR, 12'h340, 32'hF0);
        op(C_READ, 12'h340, 32'd0);
        check_eq("mscratch_final", csr_readdata, 32'h0F);
        op(C_SET, 12'hF11, 32'd0);
        check_eq("ro_set0_valid", csr_invalid, 1'b0);
        op(C_RW, 12'hF11, 32'd5);
        op(C_WRITE, 12'h305, 32'h203);
        op(C_WRITE, 12'h301, 32'h1);

        // randomized traffic
        for (int n = 0; n < 1500; n++) begin
            r = $urandom_range(0, 19);
            cmd = (r < 10) ? 4'(r) : 4'((r % 5) + 1);
            wd = $urandom;
            if ($urandom_range(0, 3) == 0) wd = 32'd0;
            else if ($urandom_range(0, 1) == 0) wd[1:0] = 2'b00;
            do_cycle(cmd, addr_tab[$urandom_range(0, 23)], wd, 31'($urandom), $urandom,
                     1'($urandom_range(0, 1)));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
